// File: rtl/blake512_padder_if.sv
// Handshake bundle between the message source, the BLAKE-512 padder and the core.
// slave is the padder's view; master is the source/core side.
interface blake512_padder_if;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          blk_valid;
  logic          blk_ready;
  logic [1023:0] blk_data;
  logic [127:0]  blk_cnt;
  logic          blk_last;

  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_cnt, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_cnt, blk_last
  );
endinterface

// File: rtl/blake512_padder.sv
// BLAKE-512 message padder: packs 64-bit big-endian words into 1024-bit blocks,
// applies 0x80 / final-bit / 128-bit length padding and tags each block with T and a last flag.
module blake512_padder #(
  parameter int unsigned LEN_W = 64
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr_all,
  blake512_padder_if.slave bus
);

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_PADX  = 2'd2;
  localparam logic [1:0] ST_SENDX = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [3:0]       wi_q, wi_d;
  logic [LEN_W-1:0] bytes_q, bytes_d;
  logic [1023:0]    data_q, data_d;
  logic [127:0]     cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             pend_q, pend_d;
  logic             pdone_q, pdone_d;

  logic             blk_valid_w;
  logic             blk_acc;
  logic [LEN_W-1:0] bytes_nx;
  logic [7:0]       pad_pos;
  logic [127:0]     len_nx;
  logic [127:0]     len_q;
  logic [3:0]       kw;
  logic [2:0]       kb;
  logic [7:0]       kp;

  assign blk_valid_w = (state_q == ST_SEND) || (state_q == ST_SENDX);
  assign blk_acc     = blk_valid_w & bus.blk_ready;
  assign bytes_nx    = bytes_q + (bus.in_last ? LEN_W'(bus.in_bytes) : LEN_W'(8));
  assign pad_pos     = {1'b0, wi_q, 3'b000} + {4'b0000, bus.in_bytes};
  // Length is bytes*8; bits above LEN_W+3 fall out as zero.
  assign len_nx      = 128'(bytes_nx) << 3;
  assign len_q       = 128'(bytes_q) << 3;

  always_comb begin
    state_d = state_q;
    wi_d    = wi_q;
    bytes_d = bytes_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    pend_d  = pend_q;
    pdone_d = pdone_q;
    kw      = '0;
    kb      = '0;
    kp      = '0;

    case (state_q)
      ST_ACC: begin
        if (bus.in_valid) begin
          bytes_d = bytes_nx;
          // Word write, tail-byte masking and 0x80/zero-fill are resolved per byte lane.
          for (int unsigned k = 0; k < 128; k++) begin
            kw = 4'(k / 8);
            kb = 3'(k % 8);
            kp = 8'(k);
            if (kw == wi_q) begin
              if (!bus.in_last || ({1'b0, kb} < bus.in_bytes))
                data_d[1023 - 8*k -: 8] = bus.in_data[63 - 8*(k % 8) -: 8];
              else
                data_d[1023 - 8*k -: 8] = '0;
            end
            if (bus.in_last) begin
              if (kp == pad_pos)
                data_d[1023 - 8*k -: 8] = 8'h80;
              else if (kp > pad_pos)
                data_d[1023 - 8*k -: 8] = '0;
            end
          end

          if (bus.in_last) begin
            state_d = ST_SEND;
            wi_d    = '0;
            cnt_d   = len_nx;
            if (pad_pos <= 8'd111) begin
              data_d[135:128] = data_d[135:128] | 8'h01;
              data_d[127:0]   = len_nx;
              last_d          = 1'b1;
              pend_d          = 1'b0;
            end else begin
              last_d  = 1'b0;
              pend_d  = 1'b1;
              pdone_d = (pad_pos != 8'd128);
            end
          end else if (wi_q == 4'd15) begin
            state_d = ST_SEND;
            wi_d    = '0;
            cnt_d   = len_nx;
            last_d  = 1'b0;
            pend_d  = 1'b0;
          end else begin
            wi_d = wi_q + 4'd1;
          end
        end
      end

      ST_SEND: begin
        if (blk_acc) begin
          if (last_q) begin
            state_d = ST_ACC;
            bytes_d = '0;
          end else if (pend_q) begin
            state_d = ST_PADX;
          end else begin
            state_d = ST_ACC;
          end
        end
      end

      ST_PADX: begin
        data_d = '0;
        if (!pdone_q)
          data_d[1023:1016] = 8'h80;
        data_d[135:128] = 8'h01;
        data_d[127:0]   = len_q;
        cnt_d           = '0;
        last_d          = 1'b1;
        pend_d          = 1'b0;
        state_d         = ST_SENDX;
      end

      ST_SENDX: begin
        if (blk_acc) begin
          state_d = ST_ACC;
          bytes_d = '0;
        end
      end

      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_ACC;
      wi_q    <= '0;
      bytes_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      pdone_q <= 1'b0;
    end else if (clr_all) begin
      state_q <= ST_ACC;
      wi_q    <= '0;
      bytes_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      pdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wi_q    <= wi_d;
      bytes_q <= bytes_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      pdone_q <= pdone_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.blk_valid = blk_valid_w;
  assign bus.blk_data  = data_q;
  assign bus.blk_cnt   = cnt_q;
  assign bus.blk_last  = last_q;

endmodule

// File: tb/tb_blake512_padder.sv
// Directed bench for blake512_padder: message lengths around the padding boundaries,
// back-pressure hold, asynchronous reset and synchronous clear.
module tb_blake512_padder;

  logic clk = 1'b0;
  logic rstb;
  logic clr_all;

  blake512_padder_if bus ();

  blake512_padder #(.LEN_W(64)) dut (
    .clk     (clk),
    .rstb    (rstb),
    .clr_all (clr_all),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [1023:0] cap_data [2];
  logic [127:0]  cap_cnt  [2];
  logic          cap_last [2];
  int unsigned   cap_n;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input int unsigned i);
    return 8'(i + 1);
  endfunction

  function automatic logic [7:0] bytek(input logic [1023:0] blk, input int unsigned k);
    return blk[1023 - 8*k -: 8];
  endfunction

  // Reference block: message bytes, 0x80 right after the message, final bit and length on the last block.
  function automatic logic [1023:0] exp_blk(input int n, input int first, input bit fin);
    logic [1023:0] e;
    e = '0;
    for (int k = 0; k < 128; k++) begin
      if (first + k < n)
        e[1023 - 8*k -: 8] = mbyte(32'(first + k));
      else if (first + k == n)
        e[1023 - 8*k -: 8] = 8'h80;
    end
    if (fin) begin
      e[135:128] = e[135:128] | 8'h01;
      e[127:0]   = 128'(n) * 128'd8;
    end
    return e;
  endfunction

  task automatic send_words(input int n, input bit close);
    int nw;
    nw = (n == 0) ? 1 : (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      logic [63:0] d;
      logic        lst;
      logic [3:0]  nb;
      int          cyc;
      lst = close && (w == nw - 1);
      nb  = lst ? 4'(n - 8*w) : 4'd8;
      for (int b = 0; b < 8; b++)
        d[63 - 8*b -: 8] = (8*w + b < n) ? mbyte(32'(8*w + b)) : 8'hEE;
      @(negedge clk);
      cyc = 0;
      while (!bus.in_ready && cyc < 300) begin
        @(negedge clk);
        cyc++;
      end
      if (!bus.in_ready) begin
        check("in_ready_wait", 128'(bus.in_ready), 128'd1);
        return;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = lst;
      bus.in_bytes = nb;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (lst)
        check($sformatf("latency_n%0d", n), 128'(bus.blk_valid), 128'd1);
    end
  endtask

  task automatic recv_check(input int n);
    int            first;
    int            cyc;
    bit            fin;
    logic [1023:0] e;
    logic [127:0]  ecnt;
    first = 0;
    cap_n = 0;
    while (cap_n < 2) begin
      @(negedge clk);
      cyc = 0;
      while (!bus.blk_valid && cyc < 300) begin
        @(negedge clk);
        cyc++;
      end
      if (!bus.blk_valid) begin
        check($sformatf("blk_wait_n%0d", n), 128'(bus.blk_valid), 128'd1);
        return;
      end
      cap_data[cap_n] = bus.blk_data;
      cap_cnt[cap_n]  = bus.blk_cnt;
      cap_last[cap_n] = bus.blk_last;
      fin  = (n - first <= 111);
      e    = exp_blk(n, first, fin);
      ecnt = (first < n) ? 128'(((n < first + 128) ? n : first + 128) * 8) : 128'd0;
      for (int s = 0; s < 8; s++)
        check($sformatf("n%0d_b%0d_slice%0d", n, cap_n, s),
              bus.blk_data[1023 - 128*s -: 128], e[1023 - 128*s -: 128]);
      check($sformatf("n%0d_b%0d_cnt", n, cap_n), bus.blk_cnt, ecnt);
      check($sformatf("n%0d_b%0d_last", n, cap_n), 128'(bus.blk_last), 128'(fin));
      bus.blk_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.blk_ready = 1'b0;
      @(negedge clk);
      check($sformatf("n%0d_b%0d_drop", n, cap_n), 128'(bus.blk_valid), 128'd0);
      cap_n++;
      if (fin) break;
      first += 128;
    end
  endtask

  task automatic run_msg(input int n);
    fork
      send_words(n, 1'b1);
      recv_check(n);
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1023:0] held;
    logic [127:0]  held_cnt;
    int            cyc;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_bytes  = '0;
    bus.blk_ready = 1'b0;
    clr_all       = 1'b0;
    rstb          = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_blk_valid", 128'(bus.blk_valid), 128'd0);
    check("rst_in_ready",  128'(bus.in_ready),  128'd1);
    check("rst_blk_data",  bus.blk_data[1023:896], 128'd0);
    check("rst_blk_cnt",   bus.blk_cnt, 128'd0);
    check("rst_blk_last",  128'(bus.blk_last), 128'd0);
    rstb = 1'b1;

    run_msg(80);
    check("m80_byte80",  128'(bytek(cap_data[0], 80)),  128'h80);
    check("m80_byte111", 128'(bytek(cap_data[0], 111)), 128'h01);
    check("m80_len",     cap_data[0][127:0], 128'h280);
    check("m80_cnt",     cap_cnt[0], 128'd640);
    check("m80_last",    128'(cap_last[0]), 128'd1);

    run_msg(0);
    check("m0_byte0",   128'(bytek(cap_data[0], 0)),   128'h80);
    check("m0_byte111", 128'(bytek(cap_data[0], 111)), 128'h01);
    check("m0_len",     cap_data[0][127:0], 128'd0);
    check("m0_cnt",     cap_cnt[0], 128'd0);

    run_msg(111);
    check("m111_byte111", 128'(bytek(cap_data[0], 111)), 128'h81);
    check("m111_len",     cap_data[0][127:0], 128'h378);
    check("m111_cnt",     cap_cnt[0], 128'd888);

    run_msg(112);
    check("m112_nblk",    128'(cap_n), 128'd2);
    check("m112_b0_b112", 128'(bytek(cap_data[0], 112)), 128'h80);
    check("m112_b0_cnt",  cap_cnt[0], 128'd896);
    check("m112_b0_last", 128'(cap_last[0]), 128'd0);
    check("m112_b1_b0",   128'(bytek(cap_data[1], 0)), 128'h00);
    check("m112_b1_b111", 128'(bytek(cap_data[1], 111)), 128'h01);
    check("m112_b1_len",  cap_data[1][127:0], 128'h380);
    check("m112_b1_cnt",  cap_cnt[1], 128'd0);
    check("m112_b1_last", 128'(cap_last[1]), 128'd1);

    run_msg(128);
    check("m128_nblk",    128'(cap_n), 128'd2);
    check("m128_b0_cnt",  cap_cnt[0], 128'd1024);
    check("m128_b0_last", 128'(cap_last[0]), 128'd0);
    check("m128_b0_b127", 128'(bytek(cap_data[0], 127)), 128'h80);
    check("m128_b1_b0",   128'(bytek(cap_data[1], 0)), 128'h80);
    check("m128_b1_b111", 128'(bytek(cap_data[1], 111)), 128'h01);
    check("m128_b1_len",  cap_data[1][127:0], 128'h400);
    check("m128_b1_cnt",  cap_cnt[1], 128'd0);

    run_msg(13);
    check("m13_byte13", 128'(bytek(cap_data[0], 13)), 128'h80);
    check("m13_byte14", 128'(bytek(cap_data[0], 14)), 128'h00);
    check("m13_len",    cap_data[0][127:0], 128'h68);

    run_msg(136);
    check("m136_b0_cnt", cap_cnt[0], 128'd1024);
    check("m136_b1_cnt", cap_cnt[1], 128'd1088);
    check("m136_b1_len", cap_data[1][127:0], 128'h440);

    // Synchronous clear part-way through a message.
    send_words(24, 1'b0);
    @(negedge clk);
    clr_all = 1'b1;
    @(posedge clk);
    #1;
    clr_all = 1'b0;
    check("clr_in_ready",  128'(bus.in_ready), 128'd1);
    check("clr_blk_data",  bus.blk_data[1023:896], 128'd0);
    run_msg(8);
    check("m8_after_clr_len", cap_data[0][127:0], 128'h40);

    // Back-pressure hold, then asynchronous reset while the block is held.
    send_words(80, 1'b1);
    @(negedge clk);
    cyc = 0;
    while (!bus.blk_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    held     = bus.blk_data;
    held_cnt = bus.blk_cnt;
    check("hold_valid0", 128'(bus.blk_valid), 128'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold_data_%0d", i), 128'(bus.blk_data == held), 128'd1);
      check($sformatf("hold_cnt_%0d", i), bus.blk_cnt, held_cnt);
      check($sformatf("hold_in_ready_%0d", i), 128'(bus.in_ready), 128'd0);
      check($sformatf("hold_valid_%0d", i), 128'(bus.blk_valid), 128'd1);
    end
    check("hold_cnt_val", held_cnt, 128'd640);
    #2;
    rstb = 1'b0;
    #1;
    check("arst_blk_valid", 128'(bus.blk_valid), 128'd0);
    check("arst_in_ready",  128'(bus.in_ready), 128'd1);
    check("arst_blk_data",  bus.blk_data[127:0], 128'd0);
    check("arst_blk_cnt",   bus.blk_cnt, 128'd0);
    @(negedge clk);
    rstb = 1'b1;
    check("arst_no_pulse",  128'(bus.blk_valid), 128'd0);

    run_msg(13);
    check("m13_after_rst_len", cap_data[0][127:0], 128'h68);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
